// File: rtl/monster_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : monster_ctrl_if
//  Description : Bundle of the monster spawn/collision controller signals:
//                frame timing, monster/doodler/bullet geometry in, and the
//                one-cycle event pulses out.
//                  master : controller side (drives the event pulses)
//                  slave  : environment side (drives geometry and status)
//  Revision    : 1.0 - initial release
// ============================================================================
interface monster_ctrl_if;
    logic       frame_clk;
    logic       game_active;
    logic       appear;
    logic [9:0] Monster_X;
    logic [9:0] Monster_Y;
    logic [9:0] Doodler_X;
    logic [9:0] Doodler_Y;
    logic [9:0] Doodler_S;
    logic       doodler_falling;
    logic       bullet_active;
    logic [9:0] Bullet_X;
    logic [9:0] Bullet_Y;
    logic       gene;
    logic       hit;
    logic       beat_monster;
    logic       stomp_bounce;
    logic       bullet_consume;
    logic       score_inc;

    modport master (
        input  frame_clk, game_active, appear,
        input  Monster_X, Monster_Y,
        input  Doodler_X, Doodler_Y, Doodler_S, doodler_falling,
        input  bullet_active, Bullet_X, Bullet_Y,
        output gene, hit, beat_monster, stomp_bounce, bullet_consume, score_inc
    );

    modport slave (
        output frame_clk, game_active, appear,
        output Monster_X, Monster_Y,
        output Doodler_X, Doodler_Y, Doodler_S, doodler_falling,
        output bullet_active, Bullet_X, Bullet_Y,
        input  gene, hit, beat_monster, stomp_bounce, bullet_consume, score_inc
    );
endinterface
`default_nettype wire

// File: rtl/monster_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : monster_ctrl
//  Description : Monster spawn and collision controller. Requests a new
//                monster after a pseudo-random cooldown, then resolves the
//                live monster against the doodler and bullet once per frame.
//  Ports       : Clk, Reset (sync, active-high)
//                bus : monster_ctrl_if.master (frame clock, geometry in,
//                      gene/hit/beat_monster/stomp_bounce/bullet_consume/
//                      score_inc pulses out, all registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module monster_ctrl #(
    parameter int unsigned MON_W         = 39,
    parameter int unsigned STOMP_MARGIN  = 8,
    parameter int unsigned COOLDOWN_BASE = 60,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  wire logic      Clk,
    input  wire logic      Reset,
    monster_ctrl_if.master bus
);

    // Counter wide enough for COOLDOWN_BASE plus the 6-bit random offset.
    localparam int                 c_cnt_w     = $clog2(COOLDOWN_BASE + 64);
    localparam logic [c_cnt_w-1:0] c_cnt_base  = c_cnt_w'(COOLDOWN_BASE);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [11:0]        c_mon_span  = 12'(MON_W - 1);
    localparam logic [11:0]        c_margin    = 12'(STOMP_MARGIN);

    localparam logic [2:0] c_st_sync     = 3'd0;
    localparam logic [2:0] c_st_cooldown = 3'd1;
    localparam logic [2:0] c_st_spawn    = 3'd2;
    localparam logic [2:0] c_st_arming   = 3'd3;
    localparam logic [2:0] c_st_alive    = 3'd4;
    localparam logic [2:0] c_st_despawn  = 3'd5;

    logic [2:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [1:0]         r_arm_cnt;
    logic [15:0]        r_lfsr;
    logic               r_frame_clk_q;
    logic               r_gene;
    logic               r_hit;
    logic               r_beat;
    logic               r_bounce;
    logic               r_consume;
    logic               r_score;

    logic               w_fe;
    logic               w_tick;
    logic               w_lfsr_fb;
    logic [c_cnt_w-1:0] w_reload;
    logic [11:0]        w_mx, w_my, w_dx, w_dy, w_ds, w_bx, w_by;
    logic               w_ovx, w_ovy, w_ov, w_stomp, w_bhit;

    assign w_fe   = bus.frame_clk & ~r_frame_clk_q;
    assign w_tick = w_fe & bus.game_active;

    // Fibonacci LFSR, taps 16/14/13/11, shifting toward bit 0.
    assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    assign w_reload  = c_cnt_base + {{(c_cnt_w-6){1'b0}}, r_lfsr[5:0]};

    // Geometry is widened so that no sum can wrap; only additions are used.
    assign w_mx = {2'b00, bus.Monster_X};
    assign w_my = {2'b00, bus.Monster_Y};
    assign w_dx = {2'b00, bus.Doodler_X};
    assign w_dy = {2'b00, bus.Doodler_Y};
    assign w_ds = {2'b00, bus.Doodler_S};
    assign w_bx = {2'b00, bus.Bullet_X};
    assign w_by = {2'b00, bus.Bullet_Y};

    assign w_ovx   = (w_dx + w_ds >= w_mx) && (w_dx <= w_mx + c_mon_span + w_ds);
    assign w_ovy   = (w_dy + w_ds >= w_my) && (w_dy <= w_my + c_mon_span + w_ds);
    assign w_ov    = w_ovx & w_ovy;
    assign w_stomp = w_ov & bus.doodler_falling & (w_dy + w_ds <= w_my + c_margin);
    assign w_bhit  = bus.bullet_active
                   & (w_bx >= w_mx) & (w_bx <= w_mx + c_mon_span)
                   & (w_by >= w_my) & (w_by <= w_my + c_mon_span);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state       <= c_st_sync;
            r_cnt         <= '0;
            r_arm_cnt     <= '0;
            r_lfsr        <= LFSR_SEED;
            r_frame_clk_q <= 1'b0;
            r_gene        <= 1'b0;
            r_hit         <= 1'b0;
            r_beat        <= 1'b0;
            r_bounce      <= 1'b0;
            r_consume     <= 1'b0;
            r_score       <= 1'b0;
        end else begin
            r_frame_clk_q <= bus.frame_clk;
            r_lfsr        <= {w_lfsr_fb, r_lfsr[15:1]};
            // Every output is a single-cycle pulse unless re-armed below.
            r_gene        <= 1'b0;
            r_hit         <= 1'b0;
            r_beat        <= 1'b0;
            r_bounce      <= 1'b0;
            r_consume     <= 1'b0;
            r_score       <= 1'b0;

            case (r_state)
                c_st_sync: begin
                    if (bus.appear) begin
                        r_state <= c_st_alive;
                    end else begin
                        r_cnt   <= w_reload;
                        r_state <= c_st_cooldown;
                    end
                end
                c_st_cooldown: begin
                    if (bus.appear) begin
                        r_state <= c_st_alive;
                    end else if (w_tick) begin
                        // gene is raised together with the SPAWN entry so it
                        // appears one cycle after the edge that empties cnt.
                        if (r_cnt == '0 || r_cnt == c_cnt_one) begin
                            r_cnt   <= '0;
                            r_gene  <= 1'b1;
                            r_state <= c_st_spawn;
                        end else begin
                            r_cnt <= r_cnt - c_cnt_one;
                        end
                    end
                end
                c_st_spawn: begin
                    r_arm_cnt <= '0;
                    r_state   <= c_st_arming;
                end
                c_st_arming: begin
                    if (bus.appear) begin
                        r_state <= c_st_alive;
                    end else if (w_tick) begin
                        if (r_arm_cnt == 2'd3) begin
                            r_gene  <= 1'b1;
                            r_state <= c_st_spawn;
                        end else begin
                            r_arm_cnt <= r_arm_cnt + 2'd1;
                        end
                    end
                end
                c_st_alive: begin
                    if (!bus.appear) begin
                        r_cnt   <= w_reload;
                        r_state <= c_st_cooldown;
                    end else if (w_tick) begin
                        if (w_bhit) begin
                            r_beat    <= 1'b1;
                            r_consume <= 1'b1;
                            r_score   <= 1'b1;
                            r_state   <= c_st_despawn;
                        end else if (w_stomp) begin
                            r_beat    <= 1'b1;
                            r_bounce  <= 1'b1;
                            r_score   <= 1'b1;
                            r_state   <= c_st_despawn;
                        end else if (w_ov) begin
                            r_hit     <= 1'b1;
                            r_state   <= c_st_despawn;
                        end
                    end
                end
                c_st_despawn: begin
                    if (!bus.appear) begin
                        r_cnt   <= w_reload;
                        r_state <= c_st_cooldown;
                    end
                end
                default: r_state <= c_st_sync;
            endcase
        end
    end

    assign bus.gene           = r_gene;
    assign bus.hit            = r_hit;
    assign bus.beat_monster   = r_beat;
    assign bus.stomp_bounce   = r_bounce;
    assign bus.bullet_consume = r_consume;
    assign bus.score_inc      = r_score;

endmodule
`default_nettype wire

// File: tb/tb_monster_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_monster_ctrl
//  Description : Self-checking bench for monster_ctrl: reset, cooldown and
//                spawn timing, stomp / side hit / bullet priority, pause,
//                mid-operation reset and randomized collision geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_monster_ctrl;

    localparam logic [15:0] SEED = 16'hACE1;

    // Observation vector order: {gene, hit, beat, bounce, consume, score}
    localparam logic [5:0] E_NONE    = 6'b000000;
    localparam logic [5:0] E_GENE    = 6'b100000;
    localparam logic [5:0] E_HIT     = 6'b010000;
    localparam logic [5:0] E_BEAT    = 6'b001000;
    localparam logic [5:0] E_BOUNCE  = 6'b000100;
    localparam logic [5:0] E_CONSUME = 6'b000010;
    localparam logic [5:0] E_SCORE   = 6'b000001;

    logic Clk = 1'b0;
    logic Reset;
    int   errors = 0;
    int   checks = 0;

    always #5 Clk = ~Clk;

    monster_ctrl_if bus ();

    monster_ctrl #(
        .MON_W         (39),
        .STOMP_MARGIN  (8),
        .COOLDOWN_BASE (60),
        .LFSR_SEED     (SEED)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    wire [5:0] w_obs = {bus.gene, bus.hit, bus.beat_monster,
                        bus.stomp_bounce, bus.bullet_consume, bus.score_inc};

    // Reference pseudo-random sequence: x^16+x^14+x^13+x^11, one step per clock.
    logic [15:0] m_lfsr;
    always @(posedge Clk) begin
        if (Reset) m_lfsr <= SEED;
        else       m_lfsr <= (m_lfsr >> 1) |
                             (16'((m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 16'h1) << 15);
    end

    // Expected event from box geometry: monster box [m, m+38], doodler box
    // [d-s, d+s]; the bullet outranks the stomp, which outranks a plain touch.
    function automatic logic [5:0] predict(int mx, int my, int dx, int dy, int ds,
                                           bit fall, bit bact, int bx, int by);
        bit ov, stomp, bhit;
        ov    = (dx + ds >= mx) && (dx - ds <= mx + 38) &&
                (dy + ds >= my) && (dy - ds <= my + 38);
        stomp = ov && fall && (dy + ds <= my + 8);
        bhit  = bact && (bx >= mx) && (bx <= mx + 38) && (by >= my) && (by <= my + 38);
        if (bhit)  return E_BEAT | E_CONSUME | E_SCORE;
        if (stomp) return E_BEAT | E_BOUNCE | E_SCORE;
        if (ov)    return E_HIT;
        return E_NONE;
    endfunction

    task automatic set_pos(int mx, int my, int dx, int dy, int ds,
                           bit fall, bit bact, int bx, int by);
        bus.Monster_X       = 10'(mx);
        bus.Monster_Y       = 10'(my);
        bus.Doodler_X       = 10'(dx);
        bus.Doodler_Y       = 10'(dy);
        bus.Doodler_S       = 10'(ds);
        bus.doodler_falling = fall;
        bus.bullet_active   = bact;
        bus.Bullet_X        = 10'(bx);
        bus.Bullet_Y        = 10'(by);
    endtask

    // One frame: frame_clk high for one clock. 'first' is sampled one cycle
    // after the edge cycle, 'later' ORs the two following cycles.
    task automatic frame(output logic [5:0] first, output logic [5:0] later);
        @(negedge Clk) bus.frame_clk = 1'b1;
        @(negedge Clk) first = w_obs;
        bus.frame_clk = 1'b0;
        later = E_NONE;
        repeat (2) begin
            @(negedge Clk) later = later | w_obs;
        end
    endtask

    // Retire whatever monster is up and bring a fresh one live at once.
    task automatic new_life();
        @(negedge Clk) bus.appear = 1'b0;
        @(negedge Clk) bus.appear = 1'b1;
    endtask

    task automatic test_reset();
        logic [5:0] f, l;
        Reset = 1'b1;
        bus.frame_clk = 1'b0;
        bus.game_active = 1'b1;
        bus.appear = 1'b1;
        set_pos(300, 300, 20, 20, 5, 1'b0, 1'b0, 0, 0);
        repeat (3) @(negedge Clk);
        checks++;
        if (w_obs !== E_NONE) begin
            errors++; $display("FAIL reset_outputs: got %b expected %b", w_obs, E_NONE);
        end
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        checks++;
        if (w_obs !== E_NONE) begin
            errors++; $display("FAIL reset_no_gene: got %b expected %b", w_obs, E_NONE);
        end
        frame(f, l);
        checks++;
        if ((f | l) !== E_NONE) begin
            errors++; $display("FAIL reset_alive_idle: got %b expected %b", f | l, E_NONE);
        end
        // Live monster after reset must be collidable right away.
        set_pos(200, 200, 195, 220, 10, 1'b0, 1'b0, 0, 0);
        frame(f, l);
        checks++;
        if (f !== E_HIT || l !== E_NONE) begin
            errors++; $display("FAIL reset_alive_hit: got %b/%b expected %b/%b", f, l, E_HIT, E_NONE);
        end
    endtask

    task automatic test_stomp();
        logic [5:0] f, l;
        set_pos(200, 200, 215, 195, 10, 1'b1, 1'b0, 0, 0);
        new_life();
        frame(f, l);
        checks++;
        if (f !== (E_BEAT | E_BOUNCE | E_SCORE) || l !== E_NONE) begin
            errors++; $display("FAIL stomp: got %b/%b expected %b/%b", f, l, E_BEAT | E_BOUNCE | E_SCORE, E_NONE);
        end
        frame(f, l);
        checks++;
        if ((f | l) !== E_NONE) begin
            errors++; $display("FAIL stomp_repeat: got %b expected %b", f | l, E_NONE);
        end
    endtask

    task automatic test_side_hit();
        logic [5:0] f, l, acc;
        set_pos(200, 200, 195, 220, 10, 1'b0, 1'b0, 0, 0);
        new_life();
        frame(f, l);
        checks++;
        if (f !== E_HIT || l !== E_NONE) begin
            errors++; $display("FAIL side_hit: got %b/%b expected %b/%b", f, l, E_HIT, E_NONE);
        end
        acc = E_NONE;
        repeat (3) begin
            frame(f, l);
            acc = acc | f | l;
        end
        checks++;
        if (acc !== E_NONE) begin
            errors++; $display("FAIL side_hit_repeat: got %b expected %b", acc, E_NONE);
        end
    endtask

    task automatic test_bullet_priority();
        logic [5:0] f, l;
        set_pos(200, 200, 215, 195, 10, 1'b1, 1'b1, 238, 238);
        new_life();
        frame(f, l);
        checks++;
        if (f !== (E_BEAT | E_CONSUME | E_SCORE) || l !== E_NONE) begin
            errors++; $display("FAIL bullet_priority: got %b/%b expected %b/%b", f, l, E_BEAT | E_CONSUME | E_SCORE, E_NONE);
        end
    endtask

    task automatic test_random();
        logic [5:0] f, l, exp_v;
        int mx, my, dx, dy, ds, bx, by;
        bit fall, bact;
        for (int t = 0; t < 30; t++) begin
            mx   = int'($urandom_range(100, 500));
            my   = int'($urandom_range(100, 500));
            ds   = int'($urandom_range(4, 20));
            dx   = mx - 30 + int'($urandom_range(0, 100));
            dy   = my - 30 + int'($urandom_range(0, 100));
            fall = 1'($urandom_range(0, 1));
            bact = ($urandom_range(0, 2) == 0);
            bx   = mx - 5 + int'($urandom_range(0, 50));
            by   = my - 5 + int'($urandom_range(0, 50));
            set_pos(mx, my, dx, dy, ds, fall, bact, bx, by);
            exp_v = predict(mx, my, dx, dy, ds, fall, bact, bx, by);
            new_life();
            frame(f, l);
            checks++;
            if (f !== exp_v) begin
                errors++; $display("FAIL random_%0d: got %b expected %b", t, f, exp_v);
            end
            frame(f, l);
            checks++;
            if ((f | l) !== E_NONE) begin
                errors++; $display("FAIL random_repeat_%0d: got %b expected %b", t, f | l, E_NONE);
            end
        end
    endtask

    task automatic test_pause_alive();
        logic [5:0] f, l, acc;
        set_pos(200, 200, 195, 220, 10, 1'b0, 1'b0, 0, 0);
        new_life();
        bus.game_active = 1'b0;
        acc = E_NONE;
        repeat (3) begin
            frame(f, l);
            acc = acc | f | l;
        end
        checks++;
        if (acc !== E_NONE) begin
            errors++; $display("FAIL pause_alive: got %b expected %b", acc, E_NONE);
        end
        bus.game_active = 1'b1;
        frame(f, l);
        checks++;
        if (f !== E_HIT) begin
            errors++; $display("FAIL pause_alive_resume: got %b expected %b", f, E_HIT);
        end
    endtask

    task automatic test_cooldown();
        logic [5:0] f, l, acc;
        int n_exp;
        set_pos(300, 300, 20, 20, 5, 1'b0, 1'b0, 0, 0);
        new_life();
        @(negedge Clk);
        bus.appear = 1'b0;
        n_exp = 60 + int'(m_lfsr[5:0]);
        acc = E_NONE;
        for (int i = 1; i < n_exp; i++) begin
            if (i == 11) begin
                bus.game_active = 1'b0;
                repeat (15) begin
                    frame(f, l);
                    acc = acc | f | l;
                end
                bus.game_active = 1'b1;
            end
            frame(f, l);
            acc = acc | f | l;
        end
        checks++;
        if (acc !== E_NONE) begin
            errors++; $display("FAIL cooldown_early: got %b expected %b (n=%0d)", acc, E_NONE, n_exp);
        end
        frame(f, l);
        checks++;
        if (f !== E_GENE || l !== E_NONE) begin
            errors++; $display("FAIL cooldown_gene: got %b/%b expected %b/%b (n=%0d)", f, l, E_GENE, E_NONE, n_exp);
        end
        acc = E_NONE;
        repeat (3) begin
            frame(f, l);
            acc = acc | f | l;
        end
        checks++;
        if (acc !== E_NONE) begin
            errors++; $display("FAIL arming_early: got %b expected %b", acc, E_NONE);
        end
        frame(f, l);
        checks++;
        if (f !== E_GENE || l !== E_NONE) begin
            errors++; $display("FAIL arming_regene: got %b/%b expected %b/%b", f, l, E_GENE, E_NONE);
        end
        set_pos(200, 200, 195, 220, 10, 1'b0, 1'b0, 0, 0);
        @(negedge Clk) bus.appear = 1'b1;
        frame(f, l);
        checks++;
        if (f !== E_HIT) begin
            errors++; $display("FAIL arming_to_alive: got %b expected %b", f, E_HIT);
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] f, l;
        set_pos(200, 200, 195, 220, 10, 1'b0, 1'b0, 0, 0);
        new_life();
        @(negedge Clk) bus.frame_clk = 1'b1;
        @(negedge Clk);
        checks++;
        if (w_obs !== E_HIT) begin
            errors++; $display("FAIL reset_mid_pulse: got %b expected %b", w_obs, E_HIT);
        end
        Reset = 1'b1;
        bus.frame_clk = 1'b0;
        @(negedge Clk);
        checks++;
        if (w_obs !== E_NONE) begin
            errors++; $display("FAIL reset_mid_clear: got %b expected %b", w_obs, E_NONE);
        end
        Reset = 1'b0;
        frame(f, l);
        checks++;
        if (f !== E_HIT || l !== E_NONE) begin
            errors++; $display("FAIL reset_mid_relive: got %b/%b expected %b/%b", f, l, E_HIT, E_NONE);
        end
    endtask

    initial begin
        test_reset();
        test_stomp();
        test_side_hit();
        test_bullet_priority();
        test_random();
        test_pause_alive();
        test_cooldown();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
